// File: rtl/model_vector_stream_transmitter.sv
// Source end of the model_vector_* vector/scalar streaming handshake.
//
// A local buffer is loaded one element at a time while idle. START checks the
// request against the buffer fill, starts the consumer, and streams SIZE_IN
// vectors of LENGTH_IN elements in row-major order. Each element after the
// first is released only by a request strobe from the consumer. Completion is
// reported after the consumer signals CONSUMER_READY.
//
// Ports:
//   CLK, RST                 clock (rising edge), async active-high reset
//   START                    begin a stream (sampled only while idle)
//   READY                    one-cycle pulse on stream completion
//   BUSY                     high from START acceptance to completion/abort
//   ERROR                    one-cycle pulse on rejected START or protocol abort
//   SIZE_IN, LENGTH_IN       vector count and elements per vector
//   LOAD_ENABLE/CLEAR/DATA   buffer load interface (idle only)
//   LOAD_FULL                buffer count equals depth
//   CONSUMER_START           one-cycle start pulse to the consumer
//   CONSUMER_READY           consumer completion pulse
//   REQUEST_VECTOR_ENABLE    consumer requests element 0 of the next vector
//   REQUEST_SCALAR_ENABLE    consumer requests the next element of a vector
//   DATA_OUT_VECTOR_ENABLE   DATA_OUT is element 0 of a vector
//   DATA_OUT_SCALAR_ENABLE   DATA_OUT is a non-first element
//   LENGTH_OUT               latched LENGTH_IN
//   DATA_OUT                 element data, holds its last value
module model_vector_stream_transmitter #(
  parameter int unsigned DATA_SIZE    = 64,
  parameter int unsigned CONTROL_SIZE = 64,
  parameter int unsigned ADDRESS_SIZE = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  output logic                    READY,
  output logic                    BUSY,
  output logic                    ERROR,
  input  logic [CONTROL_SIZE-1:0] SIZE_IN,
  input  logic [CONTROL_SIZE-1:0] LENGTH_IN,
  input  logic                    LOAD_ENABLE,
  input  logic                    LOAD_CLEAR,
  input  logic [DATA_SIZE-1:0]    LOAD_DATA,
  output logic                    LOAD_FULL,
  output logic                    CONSUMER_START,
  input  logic                    CONSUMER_READY,
  input  logic                    REQUEST_VECTOR_ENABLE,
  input  logic                    REQUEST_SCALAR_ENABLE,
  output logic                    DATA_OUT_VECTOR_ENABLE,
  output logic                    DATA_OUT_SCALAR_ENABLE,
  output logic [CONTROL_SIZE-1:0] LENGTH_OUT,
  output logic [DATA_SIZE-1:0]    DATA_OUT
);

  localparam int unsigned Depth = 2 ** ADDRESS_SIZE;
  localparam logic [ADDRESS_SIZE:0] FullCount = (ADDRESS_SIZE + 1)'(Depth);
  localparam logic [CONTROL_SIZE-1:0] CtlOne = CONTROL_SIZE'(1);
  localparam logic [ADDRESS_SIZE-1:0] PtrOne = ADDRESS_SIZE'(1);
  localparam logic [ADDRESS_SIZE:0] CountOne = (ADDRESS_SIZE + 1)'(1);

  typedef enum logic [2:0] {
    StIdle,
    StIssueStart,
    StSend,
    StWaitRequest,
    StWaitReady
  } state_e;

  state_e state_q, state_d;

  logic [CONTROL_SIZE-1:0] size_q, size_d;
  logic [CONTROL_SIZE-1:0] length_q, length_d;
  logic [CONTROL_SIZE-1:0] vec_idx_q, vec_idx_d;
  logic [CONTROL_SIZE-1:0] elem_idx_q, elem_idx_d;
  logic [ADDRESS_SIZE-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDRESS_SIZE-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDRESS_SIZE:0]   count_q, count_d;
  logic                    full_q, full_d;
  logic                    ready_q, ready_d;
  logic                    error_q, error_d;
  logic [DATA_SIZE-1:0]    data_q, data_d;

  logic                    load_write;
  logic                    last_elem;
  logic [2*CONTROL_SIZE-1:0] total_elems;

  logic [DATA_SIZE-1:0] mem [Depth];

  // Full-width product so SIZE_IN*LENGTH_IN can never wrap.
  assign total_elems = {{CONTROL_SIZE{1'b0}}, SIZE_IN} * {{CONTROL_SIZE{1'b0}}, LENGTH_IN};
  assign last_elem   = (vec_idx_q == size_q - CtlOne) && (elem_idx_q == length_q - CtlOne);

  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    length_d   = length_q;
    vec_idx_d  = vec_idx_q;
    elem_idx_d = elem_idx_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    data_d     = data_q;
    ready_d    = 1'b0;
    error_d    = 1'b0;
    load_write = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (LOAD_CLEAR) begin
          wr_ptr_d = '0;
          count_d  = '0;
        end else if (LOAD_ENABLE && (count_q != FullCount)) begin
          load_write = 1'b1;
          wr_ptr_d   = wr_ptr_q + PtrOne;
          count_d    = count_q + CountOne;
        end
        if (START) begin
          if ((SIZE_IN == '0) || (LENGTH_IN == '0) ||
              (total_elems > (2 * CONTROL_SIZE)'(count_q))) begin
            error_d = 1'b1;
          end else begin
            size_d     = SIZE_IN;
            length_d   = LENGTH_IN;
            vec_idx_d  = '0;
            elem_idx_d = '0;
            rd_ptr_d   = '0;
            state_d    = StIssueStart;
          end
        end
      end
      StIssueStart: begin
        // Data is registered on entry to StSend so it lines up with the enable.
        data_d  = mem[rd_ptr_q];
        state_d = StSend;
      end
      StSend: begin
        rd_ptr_d = rd_ptr_q + PtrOne;
        state_d  = last_elem ? StWaitReady : StWaitRequest;
        if (elem_idx_q == length_q - CtlOne) begin
          elem_idx_d = '0;
          vec_idx_d  = vec_idx_q + CtlOne;
        end else begin
          elem_idx_d = elem_idx_q + CtlOne;
        end
      end
      StWaitRequest: begin
        if (CONSUMER_READY) begin
          error_d = 1'b1;
          state_d = StIdle;
        end else if (elem_idx_q == '0) begin
          if (REQUEST_VECTOR_ENABLE) begin
            data_d  = mem[rd_ptr_q];
            state_d = StSend;
          end else if (REQUEST_SCALAR_ENABLE) begin
            error_d = 1'b1;
            state_d = StIdle;
          end
        end else begin
          if (REQUEST_VECTOR_ENABLE) begin
            error_d = 1'b1;
            state_d = StIdle;
          end else if (REQUEST_SCALAR_ENABLE) begin
            data_d  = mem[rd_ptr_q];
            state_d = StSend;
          end
        end
      end
      StWaitReady: begin
        if (CONSUMER_READY) begin
          ready_d = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    full_d = (count_d == FullCount);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= StIdle;
      size_q     <= '0;
      length_q   <= '0;
      vec_idx_q  <= '0;
      elem_idx_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      ready_q    <= 1'b0;
      error_q    <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      length_q   <= length_d;
      vec_idx_q  <= vec_idx_d;
      elem_idx_q <= elem_idx_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      ready_q    <= ready_d;
      error_q    <= error_d;
      data_q     <= data_d;
    end
  end

  // Buffer storage is not reset; an empty count makes its contents unreachable.
  always_ff @(posedge CLK) begin
    if (load_write) begin
      mem[wr_ptr_q] <= LOAD_DATA;
    end
  end

  assign READY                  = ready_q;
  assign ERROR                  = error_q;
  assign LOAD_FULL              = full_q;
  assign BUSY                   = (state_q != StIdle);
  assign CONSUMER_START         = (state_q == StIssueStart);
  assign DATA_OUT_VECTOR_ENABLE = (state_q == StSend) && (elem_idx_q == '0);
  assign DATA_OUT_SCALAR_ENABLE = (state_q == StSend) && (elem_idx_q != '0);
  assign LENGTH_OUT             = length_q;
  assign DATA_OUT               = data_q;

endmodule

// File: tb/tb_model_vector_stream_transmitter.sv
// Self-checking bench for model_vector_stream_transmitter. A queue holds the
// expected buffer contents; each stream is checked element by element against
// it while a consumer model issues requests with random delays.
module tb_model_vector_stream_transmitter;

  localparam int unsigned DW    = 64;
  localparam int unsigned CW    = 64;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;

  logic          CLK = 1'b0;
  logic          RST;
  logic          START;
  logic          READY;
  logic          BUSY;
  logic          ERROR;
  logic [CW-1:0] SIZE_IN;
  logic [CW-1:0] LENGTH_IN;
  logic          LOAD_ENABLE;
  logic          LOAD_CLEAR;
  logic [DW-1:0] LOAD_DATA;
  logic          LOAD_FULL;
  logic          CONSUMER_START;
  logic          CONSUMER_READY;
  logic          REQUEST_VECTOR_ENABLE;
  logic          REQUEST_SCALAR_ENABLE;
  logic          DATA_OUT_VECTOR_ENABLE;
  logic          DATA_OUT_SCALAR_ENABLE;
  logic [CW-1:0] LENGTH_OUT;
  logic [DW-1:0] DATA_OUT;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] model_buf [$];

  model_vector_stream_transmitter #(
    .DATA_SIZE   (DW),
    .CONTROL_SIZE(CW),
    .ADDRESS_SIZE(AW)
  ) dut (
    .CLK                   (CLK),
    .RST                   (RST),
    .START                 (START),
    .READY                 (READY),
    .BUSY                  (BUSY),
    .ERROR                 (ERROR),
    .SIZE_IN               (SIZE_IN),
    .LENGTH_IN             (LENGTH_IN),
    .LOAD_ENABLE           (LOAD_ENABLE),
    .LOAD_CLEAR            (LOAD_CLEAR),
    .LOAD_DATA             (LOAD_DATA),
    .LOAD_FULL             (LOAD_FULL),
    .CONSUMER_START        (CONSUMER_START),
    .CONSUMER_READY        (CONSUMER_READY),
    .REQUEST_VECTOR_ENABLE (REQUEST_VECTOR_ENABLE),
    .REQUEST_SCALAR_ENABLE (REQUEST_SCALAR_ENABLE),
    .DATA_OUT_VECTOR_ENABLE(DATA_OUT_VECTOR_ENABLE),
    .DATA_OUT_SCALAR_ENABLE(DATA_OUT_SCALAR_ENABLE),
    .LENGTH_OUT            (LENGTH_OUT),
    .DATA_OUT              (DATA_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, READY, 0);
    check({tag, "_busy"}, BUSY, 0);
    check({tag, "_error"}, ERROR, 0);
    check({tag, "_full"}, LOAD_FULL, 0);
    check({tag, "_cstart"}, CONSUMER_START, 0);
    check({tag, "_ven"}, DATA_OUT_VECTOR_ENABLE, 0);
    check({tag, "_sen"}, DATA_OUT_SCALAR_ENABLE, 0);
    check({tag, "_lenout"}, LENGTH_OUT, 0);
    check({tag, "_data"}, DATA_OUT, 0);
  endtask

  task automatic load(input logic [DW-1:0] v);
    LOAD_ENABLE = 1'b1;
    LOAD_DATA   = v;
    tick();
    LOAD_ENABLE = 1'b0;
    if (model_buf.size() < DEPTH) model_buf.push_back(v);
    check("load_full", LOAD_FULL, 64'(model_buf.size() == DEPTH));
  endtask

  task automatic clear(input logic with_enable);
    LOAD_CLEAR  = 1'b1;
    LOAD_ENABLE = with_enable;
    LOAD_DATA   = 64'h5a5a;
    tick();
    LOAD_CLEAR  = 1'b0;
    LOAD_ENABLE = 1'b0;
    model_buf.delete();
    check("clear_full", LOAD_FULL, 0);
  endtask

  task automatic start_reject(input int size, input int length);
    START     = 1'b1;
    SIZE_IN   = 64'(size);
    LENGTH_IN = 64'(length);
    tick();
    START = 1'b0;
    check("rej_error", ERROR, 1);
    check("rej_cstart", CONSUMER_START, 0);
    check("rej_busy", BUSY, 0);
    tick();
    check("rej_error_off", ERROR, 0);
    check("rej_busy_off", BUSY, 0);
    check("rej_cstart_off", CONSUMER_START, 0);
  endtask

  // Streams size*length elements; the expected values are the head of model_buf.
  // bad_at >= 1 answers that element with the wrong request type.
  task automatic run_stream(input int size, input int length, input int bad_at,
                            input logic busy_load);
    int n;
    int d;
    logic new_vec;
    n = size * length;
    START     = 1'b1;
    SIZE_IN   = 64'(size);
    LENGTH_IN = 64'(length);
    tick();
    START       = 1'b0;
    LOAD_ENABLE = busy_load;
    LOAD_DATA   = 64'hdead_beef;
    check("cstart", CONSUMER_START, 1);
    check("busy_start", BUSY, 1);
    check("length_out", LENGTH_OUT, 64'(length));
    check("cstart_ven", DATA_OUT_VECTOR_ENABLE, 0);
    tick();
    check("cstart_off", CONSUMER_START, 0);
    check("first_ven", DATA_OUT_VECTOR_ENABLE, 1);
    check("first_sen", DATA_OUT_SCALAR_ENABLE, 0);
    check("first_data", DATA_OUT, model_buf[0]);
    tick();
    LOAD_ENABLE = 1'b0;
    for (int k = 1; k < n; k++) begin
      d = $urandom_range(0, 2);
      check("wait_ven", DATA_OUT_VECTOR_ENABLE, 0);
      check("wait_sen", DATA_OUT_SCALAR_ENABLE, 0);
      for (int w = 0; w < d; w++) begin
        tick();
        check("wait_en", {DATA_OUT_VECTOR_ENABLE, DATA_OUT_SCALAR_ENABLE}, 0);
      end
      new_vec = ((k % length) == 0);
      if (k == bad_at) begin
        if (new_vec) REQUEST_SCALAR_ENABLE = 1'b1;
        else REQUEST_VECTOR_ENABLE = 1'b1;
        tick();
        REQUEST_VECTOR_ENABLE = 1'b0;
        REQUEST_SCALAR_ENABLE = 1'b0;
        check("abort_error", ERROR, 1);
        check("abort_busy", BUSY, 0);
        check("abort_en", {DATA_OUT_VECTOR_ENABLE, DATA_OUT_SCALAR_ENABLE}, 0);
        for (int w = 0; w < 3; w++) begin
          tick();
          check("abort_ready", READY, 0);
          check("abort_error_off", ERROR, 0);
          check("abort_en_off", {DATA_OUT_VECTOR_ENABLE, DATA_OUT_SCALAR_ENABLE}, 0);
        end
        return;
      end
      if (new_vec) begin
        REQUEST_VECTOR_ENABLE = 1'b1;
        REQUEST_SCALAR_ENABLE = 1'($urandom_range(0, 1));
      end else begin
        REQUEST_SCALAR_ENABLE = 1'b1;
      end
      tick();
      REQUEST_VECTOR_ENABLE = 1'b0;
      REQUEST_SCALAR_ENABLE = 1'b0;
      check("ven", DATA_OUT_VECTOR_ENABLE, 64'(new_vec));
      check("sen", DATA_OUT_SCALAR_ENABLE, 64'(!new_vec));
      check("data", DATA_OUT, model_buf[k]);
      check("busy_stream", BUSY, 1);
      tick();
    end
    d = $urandom_range(0, 2);
    for (int w = 0; w <= d; w++) begin
      // Stray requests while waiting for completion must be ignored.
      REQUEST_SCALAR_ENABLE = 1'($urandom_range(0, 1));
      check("wr_ready", READY, 0);
      check("wr_busy", BUSY, 1);
      check("wr_en", {DATA_OUT_VECTOR_ENABLE, DATA_OUT_SCALAR_ENABLE}, 0);
      tick();
    end
    REQUEST_SCALAR_ENABLE = 1'b0;
    check("wr_en_final", {DATA_OUT_VECTOR_ENABLE, DATA_OUT_SCALAR_ENABLE}, 0);
    CONSUMER_READY = 1'b1;
    tick();
    CONSUMER_READY = 1'b0;
    check("done_ready", READY, 1);
    check("done_busy", BUSY, 0);
    check("done_error", ERROR, 0);
    check("done_hold", DATA_OUT, model_buf[n-1]);
    tick();
    check("done_ready_off", READY, 0);
  endtask

  initial begin
    int sz;
    int ln;
    RST                   = 1'b1;
    START                 = 1'b0;
    SIZE_IN               = '0;
    LENGTH_IN             = '0;
    LOAD_ENABLE           = 1'b0;
    LOAD_CLEAR            = 1'b0;
    LOAD_DATA             = '0;
    CONSUMER_READY        = 1'b0;
    REQUEST_VECTOR_ENABLE = 1'b0;
    REQUEST_SCALAR_ENABLE = 1'b0;
    repeat (2) tick();
    check_all_zero("reset");
    RST = 1'b0;
    tick();

    // Basic 2x3 stream of 1..6.
    for (int v = 1; v <= 6; v++) load(64'(v));
    run_stream(2, 3, -1, 1'b0);

    // Too few elements, zero size, zero length.
    clear(1'b0);
    for (int v = 1; v <= 3; v++) load(64'(v));
    start_reject(2, 2);
    start_reject(0, 3);
    start_reject(3, 0);

    // Overfill: 17th write dropped, then replay of 1..16 twice.
    clear(1'b0);
    for (int v = 1; v <= 17; v++) load(64'(v));
    run_stream(4, 4, -1, 1'b0);
    run_stream(2, 8, -1, 1'b0);
    check("replay_full", LOAD_FULL, 1);

    // Wrong request type on the second element aborts.
    clear(1'b0);
    for (int v = 0; v < 4; v++) load(64'($urandom()));
    run_stream(1, 4, 1, 1'b0);
    // Wrong request type at a vector boundary aborts too.
    run_stream(2, 2, 2, 1'b0);

    // Random shapes over random data.
    for (int r = 0; r < 4; r++) begin
      clear(1'b0);
      for (int v = 0; v < 16; v++) load({$urandom(), $urandom()});
      sz = $urandom_range(1, 4);
      ln = $urandom_range(1, 16 / sz);
      run_stream(sz, ln, -1, 1'b0);
    end

    // Clear wins over a simultaneous write: buffer is empty afterwards.
    clear(1'b1);
    start_reject(1, 1);

    // Writes while busy are ignored.
    for (int v = 0; v < 15; v++) load(64'(v + 100));
    run_stream(3, 5, -1, 1'b1);
    check("busy_load_full", LOAD_FULL, 0);
    load(64'h77);
    run_stream(4, 4, -1, 1'b0);

    // Reset while waiting for a request.
    clear(1'b0);
    for (int v = 0; v < 4; v++) load(64'(v + 9));
    START     = 1'b1;
    SIZE_IN   = 64'd2;
    LENGTH_IN = 64'd2;
    tick();
    START = 1'b0;
    tick();
    tick();
    check("pre_reset_busy", BUSY, 1);
    #2 RST = 1'b1;
    #1 check_all_zero("midreset");
    tick();
    RST = 1'b0;
    model_buf.delete();
    tick();
    check("post_reset_ready", READY, 0);
    start_reject(1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/model_vector_stream_transmitter.md
Name: model_vector_stream_transmitter

Overview:
- Source end of the vector/scalar streaming handshake consumed by the model_vector_* arithmetic blocks (e.g. the summation engine).
- A local buffer is loaded element by element; on START the block starts the downstream consumer and streams SIZE_IN vectors of LENGTH_IN elements in row-major order.
- Each element after the first is released only on the consumer's request strobes. Completion is signalled once the consumer reports READY.

Parameters:
- DATA_SIZE, 64: element width.
- CONTROL_SIZE, 64: width of size/length/index fields.
- ADDRESS_SIZE, 4: buffer address width; depth = 2**ADDRESS_SIZE.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  begin a stream; sampled only in IDLE.
- READY  out  1  one-cycle pulse when the stream completes.
- BUSY  out  1  high from START acceptance until completion or abort.
- ERROR  out  1  one-cycle pulse on a rejected START or a protocol abort.
- SIZE_IN  in  CONTROL_SIZE  number of vectors.
- LENGTH_IN  in  CONTROL_SIZE  elements per vector.
- LOAD_ENABLE  in  1  write LOAD_DATA at the write pointer.
- LOAD_CLEAR  in  1  empty the buffer; write pointer and count return to 0.
- LOAD_DATA  in  DATA_SIZE  element to store.
- LOAD_FULL  out  1  count == depth.
- CONSUMER_START  out  1  one-cycle start pulse to the consumer.
- CONSUMER_READY  in  1  consumer completion pulse.
- REQUEST_VECTOR_ENABLE  in  1  consumer requests the first element of the next vector.
- REQUEST_SCALAR_ENABLE  in  1  consumer requests the next element.
- DATA_OUT_VECTOR_ENABLE  out  1  DATA_OUT is element 0 of a vector.
- DATA_OUT_SCALAR_ENABLE  out  1  DATA_OUT is a non-first element.
- LENGTH_OUT  out  CONTROL_SIZE  latched LENGTH_IN, valid while BUSY.
- DATA_OUT  out  DATA_SIZE  element data.

Behaviour:
- Reset (async, RST=1): all outputs 0. State returns to IDLE. Write pointer, read pointer, count and indices are 0. Buffer contents are not reset but are logically empty.
- Reset asserted mid-stream aborts the stream silently: no READY, no ERROR.
- Load path, active only in IDLE (LOAD_* ignored while BUSY):
  - LOAD_CLEAR has priority over LOAD_ENABLE in the same cycle.
  - A write when count == depth is dropped; pointer and count are unchanged.
  - LOAD_FULL is registered and reflects the count after the write.
- States: IDLE, ISSUE_START, SEND, WAIT_REQUEST, WAIT_READY.
- IDLE, on START:
  - Reject if SIZE_IN == 0, LENGTH_IN == 0, or SIZE_IN*LENGTH_IN > count. Rejection pulses ERROR next cycle and stays in IDLE with BUSY=0.
  - Otherwise latch SIZE/LENGTH into internal registers and LENGTH_OUT. Set vector index i=0, scalar index j=0, read pointer 0, BUSY=1. Go to ISSUE_START.
  - The product uses 2*CONTROL_SIZE bits, so there is no overflow.
- ISSUE_START: CONSUMER_START=1 for exactly one cycle, then SEND.
- SEND (one cycle):
  - DATA_OUT = mem[read pointer].
  - If j == 0, DATA_OUT_VECTOR_ENABLE=1; otherwise DATA_OUT_SCALAR_ENABLE=1. Exactly one enable is high, for one cycle.
  - Read pointer increments.
  - If the element was the last (i == SIZE-1 and j == LENGTH-1), go to WAIT_READY; otherwise WAIT_REQUEST.
  - Indices advance: j increments; at j == LENGTH-1, j returns to 0 and i increments.
- WAIT_REQUEST, next element at j == 0 (new vector):
  - Requires REQUEST_VECTOR_ENABLE=1; REQUEST_SCALAR_ENABLE may also be high and is ignored.
  - REQUEST_SCALAR_ENABLE alone is a protocol error.
- WAIT_REQUEST, next element at j > 0:
  - Requires REQUEST_SCALAR_ENABLE=1 with REQUEST_VECTOR_ENABLE=0.
  - REQUEST_VECTOR_ENABLE is a protocol error.
- WAIT_REQUEST outcomes:
  - Valid request: go to SEND. The element appears on the cycle after the request.
  - Protocol error: ERROR pulse, BUSY=0, go to IDLE, no READY.
  - CONSUMER_READY here is also a protocol error, handled the same way.
- Requests outside WAIT_REQUEST are ignored.
- WAIT_READY: on CONSUMER_READY, READY=1 for one cycle, BUSY=0, go to IDLE. Requests arriving here are ignored.
- START while BUSY is ignored.
- Data enables are 0 in every cycle except SEND. DATA_OUT holds its last value.
- Buffer contents persist after a stream, so START can replay without reloading.

Test Plan:
- Load 6 elements 1..6; SIZE=2, LENGTH=3; START; consumer model requests correctly:
  - CONSUMER_START at cycle +1, element 1 with VECTOR enable at +2.
  - Sequence: 1V, 2S, 3S, 4V, 5S, 6S, each 1 cycle after its request.
  - CONSUMER_READY then gives READY pulse, BUSY=0.
- Load 3 elements, SIZE=2, LENGTH=2, START -> ERROR pulse, no CONSUMER_START, BUSY stays 0. Same result for SIZE=0.
- Load 17 elements into a depth-16 buffer -> LOAD_FULL=1 after the 16th; 17th dropped. Replay with SIZE=4, LENGTH=4 emits values 1..16.
- SIZE=1, LENGTH=4; answer the second element with REQUEST_VECTOR_ENABLE -> ERROR pulse, BUSY=0, no further enables, no READY.
- RST asserted during WAIT_REQUEST -> all outputs 0 immediately. A subsequent START with unchanged loads is rejected (count=0).
- LOAD_CLEAR and LOAD_ENABLE in the same cycle -> count=0; LOAD_ENABLE pulsed while BUSY -> count unchanged.
